// File: rtl/multidevice_link_pkg.sv
// Shared types and constants for the multi-device link controller.
// Consumers import multidevice_link_pkg::*.
package multidevice_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RECOVER
  } link_state_t;

  localparam int unsigned N_DEV_DEF   = 4;
  localparam int unsigned DATA_W_DEF  = 3;
  localparam int unsigned TIMEOUT_DEF = 5;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multidevice_link_ctrl_if.sv
// Client/device bundle of the multi-device link: requests, one-hot active strobes,
// per-device ready, shared data bus and result/status outputs.
interface multidevice_link_ctrl_if #(
  parameter int unsigned N_DEV  = multidevice_link_pkg::N_DEV_DEF,
  parameter int unsigned DATA_W = multidevice_link_pkg::DATA_W_DEF
);
  localparam int unsigned IDX_W = multidevice_link_pkg::idx_width(N_DEV);

  logic [N_DEV-1:0]  req;
  logic [N_DEV-1:0]  active;
  logic [N_DEV-1:0]  ready;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              tmo;
  logic [DATA_W-1:0] rdata;
  logic [IDX_W-1:0]  rdev;
  logic              proto_err;

  modport master (
    input  req, ready, data,
    output active, busy, done, tmo, rdata, rdev, proto_err
  );

  modport slave (
    output req, ready, data,
    input  active, busy, done, tmo, rdata, rdev, proto_err
  );

endinterface

// File: rtl/multidevice_link_ctrl_rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first set request at or after
// i_ptr, wrapping modulo N.
module rr_arbiter
  import multidevice_link_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              i_req,
  input  logic [idx_width(N)-1:0]   i_ptr,
  output logic [idx_width(N)-1:0]   o_gnt_idx,
  output logic                      o_gnt_vld
);

  localparam int unsigned IW = idx_width(N);

  always_comb begin
    int unsigned cand;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(i_ptr) + off) % N;
      if (!o_gnt_vld && i_req[cand[IW-1:0]]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/multidevice_link_ctrl.sv
// Initiator for N_DEV targets on a shared bus: round-robin grant, one-hot active,
// capture on ready, timeout and one-cycle recovery. Optional checker: `PROTO_CHECK_EN.
module multidevice_link_ctrl
  import multidevice_link_pkg::*;
#(
  parameter int unsigned N_DEV   = N_DEV_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic                   i_clk,
  input logic                   i_rst,
  multidevice_link_ctrl_if.master link
);

  localparam int unsigned IW = idx_width(N_DEV);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  link_state_t       r_state, w_state_d;
  logic [IW-1:0]     r_gnt, r_ptr, w_ptr_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic [DATA_W-1:0] r_rdata;
  logic [IW-1:0]     r_rdev;
  logic              r_done, r_tmo;
  logic              w_done_d, w_tmo_d, w_load_gnt;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_gnt_vld;
  logic              w_ready_g;
  logic [N_DEV-1:0]  w_active;

  rr_arbiter #(
    .N (N_DEV)
  ) u_arb (
    .i_req     (link.req),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign w_ready_g = link.ready[r_gnt];

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_ptr_d    = r_ptr;
    w_done_d   = 1'b0;
    w_tmo_d    = 1'b0;
    w_load_gnt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_load_gnt = 1'b1;
          w_cnt_d    = '0;
          w_state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        // Ready has priority over the final timeout cycle.
        if (w_ready_g) begin
          w_done_d  = 1'b1;
          w_state_d = RECOVER;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_tmo_d   = 1'b1;
          w_state_d = RECOVER;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      RECOVER: begin
        w_ptr_d   = (r_gnt == IW'(N_DEV - 1)) ? '0 : r_gnt + 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_rdev  <= '0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
      r_done  <= w_done_d;
      r_tmo   <= w_tmo_d;
      if (w_load_gnt) r_gnt <= w_gnt_idx;
      if (w_done_d) begin
        r_rdata <= link.data;
        r_rdev  <= r_gnt;
      end
      if (w_tmo_d) r_rdev <= r_gnt;
    end
  end

  always_comb begin
    w_active = '0;
    if (r_state == ACTIVE) w_active[r_gnt] = 1'b1;
  end

  assign link.active = w_active;
  assign link.busy   = (r_state != IDLE);
  assign link.done   = r_done;
  assign link.tmo    = r_tmo;
  assign link.rdata  = r_rdata;
  assign link.rdev   = r_rdev;

`ifdef PROTO_CHECK_EN
  logic             r_proto_err, r_after_rec;
  logic [N_DEV-1:0] w_ready_stray;
  logic             w_ready_stuck, w_bus_undriven, w_viol;

  // The granted device may still hold ready during RECOVER; nobody else may.
  always_comb begin
    w_ready_stray = link.ready & ~w_active;
    if (r_state == RECOVER) w_ready_stray[r_gnt] = 1'b0;
  end

  assign w_ready_stuck  = r_after_rec && w_ready_g;
  assign w_bus_undriven = (r_state == ACTIVE) && w_ready_g && $isunknown(link.data);
  assign w_viol         = (|w_ready_stray) || w_ready_stuck || w_bus_undriven;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_proto_err <= 1'b0;
      r_after_rec <= 1'b0;
    end else begin
      r_after_rec <= (r_state == RECOVER);
      if (w_viol) r_proto_err <= 1'b1;
    end
  end

  assign link.proto_err = r_proto_err;

  a_active_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(w_active));
  a_done_xor_tmo: assert property (@(posedge i_clk) disable iff (i_rst) !(r_done && r_tmo));
  a_proto_rules: assert property (@(posedge i_clk) disable iff (i_rst) !w_viol)
    else $warning("link protocol rule broken by a device");
`else
  assign link.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_multidevice_link_ctrl.sv
// Randomised transaction-level bench for multidevice_link_ctrl with a grant/outcome
// reference model plus directed reset, round-robin and protocol-flag scenarios.
module tb_multidevice_link_ctrl;

  localparam int unsigned N_DEV   = 4;
  localparam int unsigned DATA_W  = 3;
  localparam int unsigned TIMEOUT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: next round-robin start and last captured data.
  int m_ptr   = 0;
  int m_rdata = 0;

  multidevice_link_ctrl_if #(.N_DEV(N_DEV), .DATA_W(DATA_W)) link ();

  multidevice_link_ctrl #(
    .N_DEV   (N_DEV),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .link  (link)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [N_DEV-1:0] vec);
    for (int off = 0; off < N_DEV; off++) begin
      if (vec[(m_ptr + off) % N_DEV]) return (m_ptr + off) % N_DEV;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N_DEV-1:0] v);
    for (int i = 0; i < N_DEV; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    link.req   = '0;
    link.ready = '0;
    link.data  = DATA_W'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    m_ptr   = 0;
    m_rdata = 0;
  endtask

  // Entered at a negedge with the DUT idle. The granted device raises ready in its
  // lat-th active cycle (0-based); lat >= TIMEOUT means it never answers.
  task automatic run_txn(input logic [N_DEV-1:0] vec, input int lat,
                         input logic [DATA_W-1:0] dval, input string tag);
    int g;
    int n_act;
    int exp_act;
    bit exp_done;
    g        = model_grant(vec);
    exp_done = (lat < TIMEOUT);
    exp_act  = exp_done ? lat + 1 : TIMEOUT;
    link.req = vec;
    @(posedge clk);
    @(negedge clk);
    n_act = 0;
    for (int k = 0; k < TIMEOUT + 2; k++) begin
      if (link.active == '0) break;
      check_eq({tag, ".active"}, 32'(link.active), 32'(1) << g);
      check_eq({tag, ".early_pulse"}, 32'(link.done | link.tmo), 0);
      n_act++;
      link.ready = '0;
      if (k == lat) begin
        link.ready[g] = 1'b1;
        link.data     = dval;
      end else begin
        link.data = DATA_W'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
    end
    link.ready = '0;
    link.req   = '0;
    if (exp_done) m_rdata = int'(dval);
    check_eq({tag, ".active_cycles"}, 32'(n_act), 32'(exp_act));
    check_eq({tag, ".done"}, 32'(link.done), 32'(exp_done));
    check_eq({tag, ".tmo"}, 32'(link.tmo), 32'(!exp_done));
    check_eq({tag, ".rdev"}, 32'(link.rdev), 32'(g));
    check_eq({tag, ".rdata"}, 32'(link.rdata), 32'(m_rdata));
    check_eq({tag, ".busy_rec"}, 32'(link.busy), 1);
    m_ptr = (g + 1) % N_DEV;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".busy_idle"}, 32'(link.busy), 0);
    check_eq({tag, ".pulse_end"}, 32'(link.done | link.tmo), 0);
  endtask

  initial begin
    int grants[$];
    int times[$];
    link.req   = '0;
    link.ready = '0;
    link.data  = '0;
    do_reset();

    check_eq("rst.active", 32'(link.active), 0);
    check_eq("rst.busy", 32'(link.busy), 0);
    check_eq("rst.done", 32'(link.done), 0);
    check_eq("rst.tmo", 32'(link.tmo), 0);
    check_eq("rst.rdata", 32'(link.rdata), 0);
    check_eq("rst.rdev", 32'(link.rdev), 0);
    check_eq("rst.proto_err", 32'(link.proto_err), 0);

    run_txn(4'b0010, 1, 3'b101, "t1");
    run_txn(4'b0100, TIMEOUT + 1, 3'b111, "t2");
    run_txn(4'b0001, TIMEOUT - 1, 3'b110, "ready_last");
    run_txn(4'b0001, TIMEOUT, 3'b011, "ready_late");

    for (int i = 0; i < 30; i++) begin
      run_txn(N_DEV'($urandom_range(1, (1 << N_DEV) - 1)), int'($urandom_range(0, TIMEOUT + 1)),
              DATA_W'($urandom), "rand");
    end

    // All clients requesting, immediate ready: grants rotate 3 cycles apart.
    do_reset();
    link.req = '1;
    for (int c = 0; c < 30 && grants.size() < 5; c++) begin
      check_eq("t3.onehot0", 32'($countones(link.active) <= 1), 1);
      if (link.active != '0) begin
        grants.push_back(onehot_idx(link.active));
        times.push_back(c);
      end
      link.ready = link.active;
      link.data  = DATA_W'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    link.req   = '0;
    link.ready = '0;
    check_eq("t3.count", 32'(grants.size()), 5);
    for (int i = 0; i < grants.size(); i++) begin
      check_eq("t3.order", 32'(grants[i]), 32'(i % N_DEV));
      if (i > 0) check_eq("t3.spacing", 32'(times[i] - times[i-1]), 3);
    end

    // Reset while device 3 is active; the pointer must restart at 0.
    do_reset();
    run_txn(4'b0010, 0, 3'b011, "t4pre");
    link.req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check_eq("t4.active3", 32'(link.active), 32'(4'b1000));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t4.active", 32'(link.active), 0);
    check_eq("t4.busy", 32'(link.busy), 0);
    check_eq("t4.pulse", 32'(link.done | link.tmo), 0);
    check_eq("t4.rdev", 32'(link.rdev), 0);
    rst      = 1'b0;
    link.req = '0;
    m_ptr    = 0;
    m_rdata  = 0;
    @(negedge clk);
    check_eq("t4.pulse_after", 32'(link.done | link.tmo), 0);
    run_txn(4'b1011, 0, 3'b111, "t4post");

    // Stray ready from device 0 while idle.
    link.ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    link.ready = '0;
`ifdef PROTO_CHECK_EN
    check_eq("t5.proto_err", 32'(link.proto_err), 1);
    repeat (3) @(negedge clk);
    check_eq("t5.sticky", 32'(link.proto_err), 1);
`else
    check_eq("t5.proto_err", 32'(link.proto_err), 0);
    repeat (3) @(negedge clk);
    check_eq("t5.still_zero", 32'(link.proto_err), 0);
`endif
    do_reset();
    check_eq("t5.cleared", 32'(link.proto_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
